// File: rtl/local_ni.sv
// local_ni: core-side network interface for the router local port.
// Credit-controlled injection FIFO plus an ejection FIFO that returns credits.
module local_ni #(
    parameter int FLIT_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int INJ_DEPTH = 4,
    parameter int EJ_DEPTH  = 4,
    parameter int CREDITS   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FLIT_W-ADDR_W-1:0] core_tx_data_i,
    input  logic [ADDR_W-1:0]        core_tx_dest_i,
    input  logic                     core_tx_valid_i,
    output logic                     core_tx_ready_o,
    output logic [FLIT_W-1:0]        local_flit_o,
    output logic                     valid_l_o,
    input  logic                     credit_i,
    input  logic [FLIT_W-1:0]        local_flit_i,
    input  logic                     valid_l_i,
    output logic                     l_incr_o,
    output logic [FLIT_W-ADDR_W-1:0] core_rx_data_o,
    output logic                     core_rx_valid_o,
    input  logic                     core_rx_ready_i,
    output logic                     ovf_o,
    output logic                     cerr_o
);

    localparam int PW  = FLIT_W - ADDR_W;
    localparam int IAW = $clog2(INJ_DEPTH);
    localparam int EAW = $clog2(EJ_DEPTH);
    localparam int CW  = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    // ---------------- injection side ----------------
    logic [FLIT_W-1:0] inj_mem_q [INJ_DEPTH];
    logic [IAW:0]      inj_wr_q, inj_rd_q;
    logic              inj_full, inj_empty;
    logic              push, send;
    logic [CW-1:0]     credit_q, credit_d;
    logic              cerr_q, cerr_d;
    logic [FLIT_W-1:0] flit_q;
    logic              vld_q;

    assign inj_empty = (inj_wr_q == inj_rd_q);
    assign inj_full  = (inj_wr_q[IAW] != inj_rd_q[IAW]) &&
                       (inj_wr_q[IAW-1:0] == inj_rd_q[IAW-1:0]);

    assign core_tx_ready_o = !inj_full;
    assign push = core_tx_valid_i && !inj_full;
    assign send = !inj_empty && (credit_q != '0);

    // Injection storage; contents are don't-care while the slot is free.
    always_ff @(posedge clk) begin
        if (push) inj_mem_q[inj_wr_q[IAW-1:0]] <= {core_tx_dest_i, core_tx_data_i};
    end

    // Credit bookkeeping: send and credit return cancel, overflow saturates.
    always_comb begin
        credit_d = credit_q;
        cerr_d   = cerr_q;
        if (send && !credit_i) begin
            credit_d = credit_q - CW'(1);
        end else if (!send && credit_i) begin
            if (credit_q == CMAX) cerr_d = 1'b1;
            else credit_d = credit_q + CW'(1);
        end
    end

    // Injection pointers, output flit register and credit state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inj_wr_q <= '0;
            inj_rd_q <= '0;
            flit_q   <= '0;
            vld_q    <= 1'b0;
            credit_q <= CMAX;
            cerr_q   <= 1'b0;
        end else begin
            if (push) inj_wr_q <= inj_wr_q + 1'b1;
            if (send) begin
                inj_rd_q <= inj_rd_q + 1'b1;
                flit_q   <= inj_mem_q[inj_rd_q[IAW-1:0]];
            end
            vld_q    <= send;
            credit_q <= credit_d;
            cerr_q   <= cerr_d;
        end
    end

    assign local_flit_o = flit_q;
    assign valid_l_o    = vld_q;
    assign cerr_o       = cerr_q;

    // ---------------- ejection side ----------------
    logic [FLIT_W-1:0] ej_mem_q [EJ_DEPTH];
    logic [EAW:0]      ej_wr_q, ej_rd_q;
    logic              ej_full, ej_empty;
    logic              ej_pop, ej_wr;
    logic              ovf_q, ovf_d;
    logic              incr_q;

    assign ej_empty = (ej_wr_q == ej_rd_q);
    assign ej_full  = (ej_wr_q[EAW] != ej_rd_q[EAW]) &&
                      (ej_wr_q[EAW-1:0] == ej_rd_q[EAW-1:0]);

    assign ej_pop = !ej_empty && core_rx_ready_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign ej_wr  = valid_l_i && (!ej_full || ej_pop);
    assign ovf_d  = ovf_q || (valid_l_i && ej_full && !ej_pop);

    // Ejection storage; the slot being read may be rewritten the same edge.
    always_ff @(posedge clk) begin
        if (ej_wr) ej_mem_q[ej_wr_q[EAW-1:0]] <= local_flit_i;
    end

    // Ejection pointers, credit return pulse and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ej_wr_q <= '0;
            ej_rd_q <= '0;
            incr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (ej_wr)  ej_wr_q <= ej_wr_q + 1'b1;
            if (ej_pop) ej_rd_q <= ej_rd_q + 1'b1;
            incr_q <= ej_pop;
            ovf_q  <= ovf_d;
        end
    end

    assign core_rx_valid_o = !ej_empty;
    assign core_rx_data_o  = ej_empty ? '0 : ej_mem_q[ej_rd_q[EAW-1:0]][PW-1:0];
    assign l_incr_o        = incr_q;
    assign ovf_o           = ovf_q;

endmodule
